// File: rtl/lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
//   lsu_state_t : FSM encoding (IDLE -> REQ -> RESP)
//   F3_*        : RV32I load/store width codes (func3)
//   MASK_*      : byte-lane strobe patterns before lane shift
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

endpackage

// File: rtl/data_mem_lsu_if.sv
// Data-memory word bus: single valid/ready handshake per access.
//   master (LSU) : drives mem_valid/we/addr/wdata/wmask, samples mem_ready/mem_rdata
//   slave (mem)  : the reverse
interface data_mem_lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              mem_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the LSU.
//   Store side : func3/addr_lo/wdata -> legal flag, replicated store data, lane mask
//   Load side  : ld_func3/ld_lo/ld_word -> extracted, sign/zero-extended result
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic        legal,
    output logic [31:0] st_data,
    output logic [3:0]  st_mask,
    input  logic [2:0]  ld_func3,
    input  logic [1:0]  ld_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);
    logic [31:0] ld_shift;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Width code and alignment; unsigned variants exist only for loads.
    always_comb begin
        legal = 1'b0;
        case (func3)
            F3_B:    legal = 1'b1;
            F3_H:    legal = !addr_lo[0];
            F3_W:    legal = (addr_lo == 2'b00);
            F3_BU:   legal = !is_store;
            F3_HU:   legal = !is_store && !addr_lo[0];
            default: legal = 1'b0;
        endcase
    end

    // Data is replicated across lanes so the strobe alone selects the target bytes.
    always_comb begin
        st_data = 32'h0;
        st_mask = 4'h0;
        case (func3[1:0])
            2'b00: begin
                st_data = {4{wdata[7:0]}};
                st_mask = MASK_B << addr_lo;
            end
            2'b01: begin
                st_data = {2{wdata[15:0]}};
                st_mask = MASK_H << addr_lo;
            end
            2'b10: begin
                st_data = wdata;
                st_mask = MASK_W;
            end
            default: ;
        endcase
    end

    assign ld_shift = ld_word >> {ld_lo, 3'b000};
    assign ld_byte  = ld_shift[7:0];
    assign ld_half  = ld_shift[15:0];

    always_comb begin
        ld_data = ld_word;
        case (ld_func3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_BU:   ld_data = {24'h0, ld_byte};
            F3_HU:   ld_data = {16'h0, ld_half};
            default: ld_data = ld_word;
        endcase
    end
endmodule

// File: rtl/data_mem_lsu.sv
// Load/store responder for EX/MEM. Turns each decoded memory access into one
// valid/ready word transaction, stalling the pipeline until it completes.
//   clk, rst_n          : clock, async active-low reset
//   cs, wr_en, rd_en    : decoder controls (cs/wr_en active-low, rd_en active-high)
//   func3, addr, wdata  : width code, byte address, store data
//   rdata               : registered load result
//   stall               : hold pipeline
//   access_err, bus_err : 1-cycle pulses (misaligned/illegal func3, timeout)
//   mem                 : data-memory bus (master side)
module data_mem_lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              access_err,
    output logic              bus_err,
    data_mem_lsu_if.master    mem
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // Abort decision is made in the cycle whose increment would reach TIMEOUT-1.
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 2);

    lsu_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              valid_q, valid_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [31:0]       mwdata_q, mwdata_d;
    logic [3:0]        mask_q, mask_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lo_q, lo_d;
    logic              aerr_q, aerr_d;
    logic              berr_q, berr_d;

    logic        is_store, is_load, legal;
    logic [31:0] st_data, ld_data;
    logic [3:0]  st_mask;

    // Store wins when both decode terms could apply.
    assign is_store = !cs && !wr_en;
    assign is_load  = !cs && wr_en && rd_en;

    lsu_align u_align (
        .is_store (is_store),
        .func3    (func3),
        .addr_lo  (addr[1:0]),
        .wdata    (wdata),
        .legal    (legal),
        .st_data  (st_data),
        .st_mask  (st_mask),
        .ld_func3 (f3_q),
        .ld_lo    (lo_q),
        .ld_word  (mem.mem_rdata),
        .ld_data  (ld_data)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        valid_d  = valid_q;
        we_d     = we_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        mask_d   = mask_q;
        f3_d     = f3_q;
        lo_d     = lo_q;
        aerr_d   = 1'b0;
        berr_d   = 1'b0;
        stall    = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_store || is_load) begin
                    if (legal) begin
                        stall    = 1'b1;
                        state_d  = REQ;
                        cnt_d    = '0;
                        valid_d  = 1'b1;
                        we_d     = is_store;
                        maddr_d  = {addr[ADDR_W-1:2], 2'b00};
                        mwdata_d = is_store ? st_data : 32'h0;
                        mask_d   = is_store ? st_mask : 4'h0;
                        f3_d     = func3;
                        lo_d     = addr[1:0];
                    end else begin
                        aerr_d = 1'b1;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                // Ready is checked first so a handshake on the limit cycle succeeds.
                if (mem.mem_ready) begin
                    valid_d = 1'b0;
                    state_d = RESP;
                    if (!we_q) rdata_d = ld_data;
                end else if (cnt_q == LIMIT) begin
                    valid_d = 1'b0;
                    berr_d  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rdata_q  <= '0;
            valid_q  <= 1'b0;
            we_q     <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            mask_q   <= '0;
            f3_q     <= '0;
            lo_q     <= '0;
            aerr_q   <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            valid_q  <= valid_d;
            we_q     <= we_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            mask_q   <= mask_d;
            f3_q     <= f3_d;
            lo_q     <= lo_d;
            aerr_q   <= aerr_d;
            berr_q   <= berr_d;
        end
    end

    assign rdata         = rdata_q;
    assign access_err    = aerr_q;
    assign bus_err       = berr_q;
    assign mem.mem_valid = valid_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = maddr_q;
    assign mem.mem_wdata = mwdata_q;
    assign mem.mem_wmask = mask_q;
endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: vector table for single accesses plus
// hand-written sequences for wait states, timeout, ready-on-limit and reset.
module tb_data_mem_lsu;
    import lsu_pkg::*;

    logic        clk, rst_n;
    logic        cs, wr_en, rd_en;
    logic [2:0]  func3;
    logic [31:0] addr, wdata, rdata;
    logic        stall, access_err, bus_err;

    data_mem_lsu_if bus ();

    data_mem_lsu #(.TIMEOUT(16), .ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs         (cs),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .func3      (func3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .stall      (stall),
        .access_err (access_err),
        .bus_err    (bus_err),
        .mem        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        cs, wr_en, rd_en;
        logic [2:0]  f3;
        logic [31:0] addr, wd, mrd;
        logic        ok, err, we;
        logic [31:0] maddr, mwd;
        logic [3:0]  mask;
        logic [31:0] rd;
    } vec_t;

    localparam int NV = 15;
    vec_t vec [NV];

    initial begin
        int n, ns;
        logic got;

        //           cs wr rd f3     addr          wdata         mem_rdata     ok err we maddr         mwdata        mask     rdata
        vec[0]  = '{0, 0, 0, F3_W,  32'h100, 32'hDEADBEEF, 32'h0,        1, 0, 1, 32'h100, 32'hDEADBEEF, 4'b1111, 32'h0};
        vec[1]  = '{0, 1, 1, F3_B,  32'h203, 32'hCAFE0000, 32'h80FF0000, 1, 0, 0, 32'h200, 32'h0,        4'b0000, 32'hFFFFFF80};
        vec[2]  = '{0, 1, 1, F3_BU, 32'h203, 32'hCAFE0000, 32'h80FF0000, 1, 0, 0, 32'h200, 32'h0,        4'b0000, 32'h00000080};
        vec[3]  = '{0, 0, 0, F3_H,  32'h102, 32'h00001234, 32'h0,        1, 0, 1, 32'h100, 32'h12341234, 4'b1100, 32'h00000080};
        vec[4]  = '{0, 0, 0, F3_B,  32'h101, 32'h000000A5, 32'h0,        1, 0, 1, 32'h100, 32'hA5A5A5A5, 4'b0010, 32'h00000080};
        vec[5]  = '{0, 1, 1, F3_H,  32'h102, 32'h0,        32'h80017FFF, 1, 0, 0, 32'h100, 32'h0,        4'b0000, 32'hFFFF8001};
        vec[6]  = '{0, 1, 1, F3_HU, 32'h102, 32'h0,        32'h80017FFF, 1, 0, 0, 32'h100, 32'h0,        4'b0000, 32'h00008001};
        vec[7]  = '{0, 1, 1, F3_W,  32'h300, 32'h0,        32'h12345678, 1, 0, 0, 32'h300, 32'h0,        4'b0000, 32'h12345678};
        vec[8]  = '{0, 1, 1, F3_W,  32'h101, 32'h0,        32'h0,        0, 1, 0, 32'h0,   32'h0,        4'b0000, 32'h12345678};
        vec[9]  = '{0, 0, 0, F3_H,  32'h103, 32'h0,        32'h0,        0, 1, 0, 32'h0,   32'h0,        4'b0000, 32'h12345678};
        vec[10] = '{0, 0, 0, F3_BU, 32'h100, 32'h0,        32'h0,        0, 1, 0, 32'h0,   32'h0,        4'b0000, 32'h12345678};
        vec[11] = '{0, 1, 1, 3'b011,32'h100, 32'h0,        32'h0,        0, 1, 0, 32'h0,   32'h0,        4'b0000, 32'h12345678};
        vec[12] = '{0, 1, 0, F3_W,  32'h100, 32'h0,        32'h0,        0, 0, 0, 32'h0,   32'h0,        4'b0000, 32'h12345678};
        vec[13] = '{0, 0, 1, F3_B,  32'h100, 32'h00000011, 32'h0,        1, 0, 1, 32'h100, 32'h11111111, 4'b0001, 32'h12345678};
        vec[14] = '{0, 1, 1, F3_H,  32'h000, 32'h0,        32'h00008000, 1, 0, 0, 32'h000, 32'h0,        4'b0000, 32'hFFFF8000};

        rst_n = 1'b0; cs = 1'b1; wr_en = 1'b1; rd_en = 1'b0;
        func3 = 3'b0; addr = 32'h0; wdata = 32'h0;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        #12;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_valid", bus.mem_valid, 1'b0);
        chk("rst_we", bus.mem_we, 1'b0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_wmask", bus.mem_wmask, 4'h0);
        chk("rst_errs", {access_err, bus_err}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            cs = vec[i].cs; wr_en = vec[i].wr_en; rd_en = vec[i].rd_en;
            func3 = vec[i].f3; addr = vec[i].addr; wdata = vec[i].wd;
            bus.mem_ready = 1'b0;
            #1;
            chk($sformatf("v%0d_stall_idle", i), stall, vec[i].ok);
            tick();
            if (vec[i].ok) begin
                chk($sformatf("v%0d_valid", i), bus.mem_valid, 1'b1);
                chk($sformatf("v%0d_we", i), bus.mem_we, vec[i].we);
                chk($sformatf("v%0d_addr", i), bus.mem_addr, vec[i].maddr);
                if (vec[i].we) begin
                    chk($sformatf("v%0d_wdata", i), bus.mem_wdata, vec[i].mwd);
                    chk($sformatf("v%0d_wmask", i), bus.mem_wmask, vec[i].mask);
                end
                chk($sformatf("v%0d_stall_req", i), stall, 1'b1);
                bus.mem_ready = 1'b1; bus.mem_rdata = vec[i].mrd;
                tick();
                bus.mem_ready = 1'b0; bus.mem_rdata = 32'hBAD0BAD0;
                chk($sformatf("v%0d_valid_resp", i), bus.mem_valid, 1'b0);
                chk($sformatf("v%0d_stall_resp", i), stall, 1'b0);
                chk($sformatf("v%0d_rdata", i), rdata, vec[i].rd);
                chk($sformatf("v%0d_noerr", i), {access_err, bus_err}, 2'b00);
                cs = 1'b1;
                tick();
                chk($sformatf("v%0d_valid_idle", i), bus.mem_valid, 1'b0);
            end else begin
                chk($sformatf("v%0d_access_err", i), access_err, vec[i].err);
                chk($sformatf("v%0d_novalid", i), bus.mem_valid, 1'b0);
                chk($sformatf("v%0d_stall", i), stall, 1'b0);
                cs = 1'b1;
                tick();
                chk($sformatf("v%0d_err_clr", i), access_err, 1'b0);
                chk($sformatf("v%0d_rdata", i), rdata, vec[i].rd);
            end
        end

        // Two wait states: 2 + 2 stall cycles.
        cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0; func3 = F3_W; addr = 32'h700; wdata = 32'h1;
        bus.mem_ready = 1'b0;
        #1;
        ns = stall ? 1 : 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!stall) break;
            ns++;
            if (k == 2) bus.mem_ready = 1'b1;
        end
        bus.mem_ready = 1'b0;
        chk("wait2_stall_cycles", ns, 4);
        cs = 1'b1;
        tick();

        // Timeout: ready never comes.
        cs = 1'b0; wr_en = 1'b1; rd_en = 1'b1; func3 = F3_W; addr = 32'h500;
        n = 0; got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            if (bus_err) got = 1'b1;
            else if (bus.mem_valid) n++;
        end
        chk("to_seen", got, 1'b1);
        chk("to_req_cycles", n, 15);
        chk("to_valid_drop", bus.mem_valid, 1'b0);
        chk("to_stall_rel", stall, 1'b0);
        chk("to_rdata_keep", rdata, 32'hFFFF8000);
        cs = 1'b1;
        tick();
        chk("to_err_pulse", bus_err, 1'b0);
        chk("to_idle_valid", bus.mem_valid, 1'b0);

        // Ready arriving on the limit cycle wins over the timeout.
        cs = 1'b0; wr_en = 1'b1; rd_en = 1'b1; func3 = F3_W; addr = 32'h600;
        tick();
        for (int k = 0; k < 14; k++) tick();
        chk("lim_valid_c15", bus.mem_valid, 1'b1);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hA5A50001;
        tick();
        bus.mem_ready = 1'b0;
        chk("lim_bus_err", bus_err, 1'b0);
        chk("lim_rdata", rdata, 32'hA5A50001);
        chk("lim_stall", stall, 1'b0);
        cs = 1'b1;
        tick();

        // Reset in the middle of a waiting store.
        cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0; func3 = F3_W; addr = 32'h800; wdata = 32'h55;
        tick();
        for (int k = 0; k < 3; k++) tick();
        chk("mid_valid_pre", bus.mem_valid, 1'b1);
        cs = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.mem_valid, 1'b0);
        chk("mid_rst_stall", stall, 1'b0);
        chk("mid_rst_rdata", rdata, 32'h0);
        chk("mid_rst_we", bus.mem_we, 1'b0);
        chk("mid_rst_addr", bus.mem_addr, 32'h0);
        chk("mid_rst_wdata", bus.mem_wdata, 32'h0);
        chk("mid_rst_wmask", bus.mem_wmask, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Ready outside REQ is ignored.
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h13572468;
        tick();
        tick();
        bus.mem_ready = 1'b0;
        chk("stray_ready_rdata", rdata, 32'h0);
        chk("stray_ready_valid", bus.mem_valid, 1'b0);
        chk("stray_ready_stall", stall, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
